// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures mon_clk period in clk cycles and flags out-of-range or stopped clocks.
module clk_period_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic [CNT_W-1:0] min_period,
    input  logic [CNT_W-1:0] max_period,
    input  logic [CNT_W-1:0] timeout,
    input  logic             clear_flags,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             stopped,
    output logic [31:0]      edge_count
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic last_q, rise, report, stop_hit;
    logic [CNT_W-1:0] cnt, cnt_n;
    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // A rise outranks the timeout compare, so a period equal to timeout still reports.
    always_comb begin
        state_n  = state;
        cnt_n    = '0;
        report   = 1'b0;
        stop_hit = 1'b0;
        if (!enable) state_n = IDLE;
        else case (state)
            IDLE: state_n = ARM;
            ARM: begin
                state_n = rise ? MEASURE : ARM;
                cnt_n   = rise ? CNT_W'(1) : '0;
            end
            MEASURE: begin
                if (rise) begin
                    report = 1'b1;
                    cnt_n  = CNT_W'(1);
                end else if (timeout != '0 && cnt == timeout) begin
                    stop_hit = 1'b1;
                    state_n  = ARM;
                end else cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_out   <= '0;
            period_valid <= 1'b0;
            too_fast     <= 1'b0;
            too_slow     <= 1'b0;
            stopped      <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= report;
            if (report) period_out <= cnt;
            too_fast <= (too_fast & ~clear_flags) | (report && cnt < min_period);
            too_slow <= (too_slow & ~clear_flags) | (report && cnt > max_period);
            stopped  <= (stopped & ~clear_flags) | stop_hit;
            if (enable && state != IDLE && rise) edge_count <= edge_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: directed bench with an expected-period scoreboard for clk_period_monitor.
module tb_clk_period_monitor;
    logic        clk = 1'b0;
    logic        rst_n, mon_clk, enable, clear_flags;
    logic [15:0] min_period, max_period, timeout;
    logic [15:0] period_out;
    logic        period_valid, too_fast, too_slow, stopped;
    logic [31:0] edge_count;
    int tests = 0;
    int fails = 0;
    int exp_q[$];

    clk_period_monitor #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .enable(enable),
        .min_period(min_period), .max_period(max_period), .timeout(timeout),
        .clear_flags(clear_flags), .period_out(period_out), .period_valid(period_valid),
        .too_fast(too_fast), .too_slow(too_slow), .stopped(stopped), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every report pops the oldest expected period; a report with nothing queued is an error.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (period_valid) begin
                chk("report_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("period_out", 32'(period_out), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // Rise lands p cycles after the previous rise; exp < 0 means no report is expected.
    task automatic mon_cycle(input int p, input int exp);
        mon_clk = 1'b0;
        cycles(p - 3);
        if (exp >= 0) exp_q.push_back(exp);
        mon_clk = 1'b1;
        cycles(3);
        chk("report_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rearm();
        enable = 1'b0;
        cycles(1);
        enable = 1'b1;
        cycles(1);
    endtask

    task automatic clear_pulse();
        clear_flags = 1'b1;
        cycles(1);
        clear_flags = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mon_clk = 1'b0; enable = 1'b0; clear_flags = 1'b0;
        min_period = 16'd8; max_period = 16'd12; timeout = 16'd100;
        cycles(3);
        chk("rst_period_out", 32'(period_out), 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_flags", {29'd0, too_fast, too_slow, stopped}, 32'd0);
        chk("rst_edge_count", edge_count, 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        cycles(2);
        // Nominal 10-cycle clock inside the legal window.
        mon_cycle(10, -1);
        repeat (3) mon_cycle(10, 10);
        chk("nominal_flags", {29'd0, too_fast, too_slow, stopped}, 32'd0);
        chk("nominal_edges", edge_count, 32'd4);
        // Too-fast clock, sticky flag, clear and re-set.
        rearm();
        mon_cycle(6, -1);
        mon_cycle(6, 6);
        chk("fast_set", 32'(too_fast), 32'd1);
        chk("fast_no_slow", 32'(too_slow), 32'd0);
        mon_clk = 1'b0;
        clear_pulse();
        chk("fast_cleared", 32'(too_fast), 32'd0);
        mon_cycle(6, 7);
        chk("fast_reset", 32'(too_fast), 32'd1);
        cycles(2);
        chk("fast_sticky", 32'(too_fast), 32'd1);
        // Window boundaries and inverted limits.
        timeout = 16'd0;
        rearm();
        clear_pulse();
        mon_cycle(8, -1);
        mon_cycle(8, 8);
        mon_cycle(12, 12);
        chk("bound_legal", {30'd0, too_fast, too_slow}, 32'd0);
        mon_cycle(13, 13);
        chk("bound_slow", {30'd0, too_fast, too_slow}, 32'd1);
        min_period = 16'd10; max_period = 16'd5;
        clear_pulse();
        chk("bound_cleared", {30'd0, too_fast, too_slow}, 32'd0);
        mon_cycle(7, 8);
        chk("inverted_both", {30'd0, too_fast, too_slow}, 32'd3);
        // Stopped clock detection.
        min_period = 16'd8; max_period = 16'd12; timeout = 16'd50;
        rearm();
        clear_pulse();
        mon_cycle(10, -1);
        mon_cycle(10, 10);
        mon_clk = 1'b0;
        cycles(49);
        chk("stop_early", 32'(stopped), 32'd0);
        cycles(1);
        chk("stop_set", 32'(stopped), 32'd1);
        chk("stop_period_kept", 32'(period_out), 32'd10);
        mon_cycle(9, -1);
        mon_cycle(9, 9);
        chk("stop_resume_sticky", 32'(stopped), 32'd1);
        // Rise exactly at the timeout count.
        timeout = 16'd20; max_period = 16'd30;
        rearm();
        clear_pulse();
        mon_cycle(20, -1);
        mon_cycle(20, 20);
        mon_cycle(20, 20);
        chk("coincident_no_stop", 32'(stopped), 32'd0);
        // Reset mid-period, then enable toggling.
        timeout = 16'd0; max_period = 16'd12;
        rearm();
        mon_cycle(10, -1);
        mon_clk = 1'b0;
        cycles(4);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        chk("mid_rst_period_out", 32'(period_out), 32'd0);
        chk("mid_rst_valid", 32'(period_valid), 32'd0);
        chk("mid_rst_flags", {29'd0, too_fast, too_slow, stopped}, 32'd0);
        chk("mid_rst_edges", edge_count, 32'd0);
        cycles(1);
        mon_cycle(10, -1);
        mon_cycle(10, 10);
        chk("post_rst_edges", edge_count, 32'd2);
        enable = 1'b0;
        cycles(2);
        mon_cycle(10, -1);
        chk("disabled_edges", edge_count, 32'd2);
        chk("disabled_period", 32'(period_out), 32'd10);
        enable = 1'b1;
        cycles(1);
        mon_cycle(10, -1);
        mon_cycle(10, 10);
        chk("reenabled_edges", edge_count, 32'd4);
        // Saturation with stopped detection disabled.
        min_period = 16'd0; max_period = 16'hFFFF; timeout = 16'd0;
        rearm();
        clear_pulse();
        mon_cycle(10, -1);
        mon_clk = 1'b0;
        cycles(70000);
        exp_q.push_back(32'hFFFF);
        mon_clk = 1'b1;
        cycles(3);
        chk("sat_drained", 32'(exp_q.size()), 32'd0);
        chk("sat_flags", {29'd0, too_fast, too_slow, stopped}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
